// File: rtl/ram_stream_reader.sv
// ram_stream_reader: issues sequential RAM reads for a (start, length) request and
// streams the words out over valid/ready with a last flag and a done pulse.
`default_nettype none

module ram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid_i,
    output logic                  start_ready_o,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic [ADDR_WIDTH:0]   start_len_i,
    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_dout_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [ADDR_WIDTH:0] LEN_ZERO = '0;
    localparam logic [ADDR_WIDTH:0] LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   rem_q;
    logic                  inflight_q;
    logic                  inflight_last_q;
    logic                  done_q;

    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic                  fifo_last_q [2];
    logic                  rd_ptr_q, wr_ptr_q;
    logic [1:0]            count_q, count_d;

    logic w_accept, w_pop, w_fifo_pop, w_push, w_last_pop, w_last_issue;

    assign w_accept     = start_valid_i && start_ready_o;
    assign w_pop        = out_valid_o && out_ready_i;
    assign w_fifo_pop   = w_pop && (count_q != 2'd0);
    // A word arriving from the RAM bypasses storage when the buffer is empty and it is taken at once.
    assign w_push       = inflight_q && !(w_pop && (count_q == 2'd0));
    assign w_last_pop   = w_pop && out_last_o;
    assign w_last_issue = ram_en_o && (rem_q == LEN_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_valid_i && (start_len_i != LEN_ZERO)) state_d = S_READ;
            S_READ:  if (w_last_issue) state_d = S_DRAIN;
            S_DRAIN: if (w_last_pop) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        start_ready_o = (state_q == S_IDLE);
        busy_o        = (state_q != S_IDLE);
        ram_en_o      = (state_q == S_READ) && ((count_q + {1'b0, inflight_q}) < 2'd2);
    end

    assign ram_addr_o = addr_q;
    assign done_o     = done_q;

    always_comb begin
        out_valid_o = (count_q != 2'd0) || inflight_q;
        out_data_o  = '0;
        out_last_o  = 1'b0;
        if (count_q != 2'd0) begin
            out_data_o = fifo_data_q[rd_ptr_q];
            out_last_o = fifo_last_q[rd_ptr_q];
        end else if (inflight_q) begin
            out_data_o = ram_dout_i;
            out_last_o = inflight_last_q;
        end
    end

    always_comb begin
        count_d = count_q;
        if (w_push && !w_fifo_pop) begin
            count_d = count_q + 2'd1;
        end else if (!w_push && w_fifo_pop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            if (w_accept) begin
                addr_q <= start_addr_i;
                rem_q  <= start_len_i;
            end else if (ram_en_o) begin
                addr_q <= addr_q + 1'b1;
                rem_q  <= rem_q - LEN_ONE;
            end
            inflight_q      <= ram_en_o;
            inflight_last_q <= w_last_issue;
            done_q          <= (w_accept && (start_len_i == LEN_ZERO)) ||
                               ((state_q == S_DRAIN) && w_last_pop);
            if (w_push) begin
                fifo_data_q[wr_ptr_q] <= ram_dout_i;
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (w_fifo_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
// Testbench for ram_stream_reader: registered-read RAM model plus a queue-based
// expected stream built from start address and length.
`default_nettype none

module tb_ram_stream_reader;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid, start_ready;
    logic [AW-1:0] start_addr;
    logic [AW:0]   start_len;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout = '0;
    logic          out_valid, out_ready, out_last, busy, done;
    logic [DW-1:0] out_data;

    logic [DW-1:0] mem [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_valid_i (start_valid),
        .start_ready_o (start_ready),
        .start_addr_i  (start_addr),
        .start_len_i   (start_len),
        .ram_en_o      (ram_en),
        .ram_addr_o    (ram_addr),
        .ram_dout_i    (ram_dout),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_data_o    (out_data),
        .out_last_o    (out_last),
        .busy_o        (busy),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // mode: 0 ready always 1, 1 random ready, 2 ready pattern 1,0,0 repeating.
    // hold: keep start_valid high with (next_addr,next_len) so the next request follows done.
    // skip_start: the request was already accepted at the end of the previous call.
    task automatic run_req(input int addr, input int len, input int mode, input int abort_after,
                           input bit hold, input int next_addr, input int next_len,
                           input bit skip_start);
        logic [DW:0]   exp_q [$];
        logic [DW:0]   e;
        logic [DW-1:0] prev_data;
        logic          prev_last, prev_stall;
        int issued, popped, done_idx, first_en, first_v;
        bit aborted;
        for (int i = 0; i < len; i++)
            exp_q.push_back({(i == len - 1), mem[(addr + i) % DEPTH]});
        if (!skip_start) begin
            @(negedge clk);
            start_valid = 1'b1;
            start_addr  = addr[AW-1:0];
            start_len   = len[AW:0];
            check("start_ready_idle", start_ready, 1);
            @(posedge clk);
            #1;
            if (hold) begin
                start_addr = next_addr[AW-1:0];
                start_len  = next_len[AW:0];
            end else begin
                start_valid = 1'b0;
            end
        end
        issued = 0; popped = 0; done_idx = -1; first_en = -1; first_v = -1;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; aborted = 1'b0;
        for (int idx = 1; idx <= 400; idx++) begin
            @(negedge clk);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = ((idx % 3) == 1);
            endcase
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_last", out_last, prev_last);
            end
            check("busy", busy, !done);
            check("start_ready", start_ready, !busy);
            if (ram_en) begin
                check("ram_addr", ram_addr, (addr + issued) % DEPTH);
                issued++;
                if (first_en < 0) first_en = idx;
            end
            check("outstanding_le2", ((issued - popped) <= 2), 1);
            if (out_valid && first_v < 0) first_v = idx;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e[DW-1:0]);
                    check("out_last", out_last, e[DW]);
                end
                popped++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (done) begin
                done_idx = idx;
                break;
            end
            if (abort_after > 0 && popped == abort_after) begin
                rst = 1'b1;
                #1;
                check("abort_valid", out_valid, 0);
                check("abort_ram_en", ram_en, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_start_ready", start_ready, 1);
                check("abort_data", out_data, 0);
                repeat (2) @(negedge clk);
                check("abort_no_done", done, 0);
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            check("done_seen", (done_idx > 0), 1);
            check("word_count", popped, len);
            check("issue_count", issued, len);
            check("exp_empty", exp_q.size(), 0);
            if (mode == 0) begin
                if (len > 0) begin
                    check("lat_ram_en", first_en, 1);
                    check("lat_out_valid", first_v, 2);
                    check("lat_done", done_idx, len + 2);
                end else begin
                    check("len0_done", done_idx, 1);
                    check("len0_no_valid", first_v, -1);
                end
            end
            if (hold) begin
                @(posedge clk);
                #1;
                start_valid = 1'b0;
            end else begin
                @(negedge clk);
                check("done_pulse", done, 0);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start_valid = 1'b0; start_addr = '0; start_len = '0; out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        repeat (3) @(negedge clk);
        check("rst_start_ready", start_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_done", done, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_ram_addr", ram_addr, 0);
        rst = 1'b0;

        mem[3] = 8'hA0; mem[4] = 8'hA1; mem[5] = 8'hA2; mem[6] = 8'hA3;
        run_req(3, 4, 0, 0, 1'b0, 0, 0, 1'b0);
        run_req(30, 4, 0, 0, 1'b0, 0, 0, 1'b0);
        run_req(10, 5, 2, 0, 1'b0, 0, 0, 1'b0);
        run_req(7, 0, 0, 0, 1'b0, 0, 0, 1'b0);
        run_req(20, 6, 1, 0, 1'b1, 1, 3, 1'b0);
        run_req(1, 3, 1, 0, 1'b0, 0, 0, 1'b1);
        run_req(12, 8, 0, 2, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        run_req(12, 8, 0, 0, 1'b0, 0, 0, 1'b0);
        run_req(17, 32, 1, 0, 1'b0, 0, 0, 1'b0);
        run_req(0, 32, 0, 0, 1'b0, 0, 0, 1'b0);
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
            run_req(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH)),
                    int'($urandom_range(0, 2)), 0, 1'b0, 0, 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
